// File: rtl/mips_alu_mc.sv
// mips_alu_mc: registered MIPS EX-stage ALU with iterative mult/div on HI/LO; define ALU_DIV_EN to build the divider
module mips_alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         OpSel,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   Res,
  output logic               zero,
  output logic               overflow,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res_q, hi_q, lo_q, b_q;
  logic zero_q, ovf_q, busy_q, done_q, neg_q;
  logic [WIDTH-1:0] res_d, sum, diff, mag_a, mag_b;
  logic ovf_d, is_signed, is_mul, is_multi;
  logic [WIDTH:0] acc;
  logic [WIDTH-1:0] mul_hi, mul_lo, step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod;
  assign Res      = res_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign sum       = A + B;
  assign diff      = A - B;
  assign is_signed = !OpSel[0];
  assign is_mul    = OpSel == 6'h18 || OpSel == 6'h19;
  assign mag_a     = (is_signed && A[WIDTH-1]) ? -A : A;
  assign mag_b     = (is_signed && B[WIDTH-1]) ? -B : B;
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (OpSel)
      6'h24: res_d = A & B;
      6'h25: res_d = A | B;
      6'h26: res_d = A ^ B;
      6'h27: res_d = ~(A | B);
      6'h20: begin
        res_d = sum;
        ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      6'h21: res_d = sum;
      6'h22: begin
        res_d = diff;
        ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      6'h23: res_d = diff;
      6'h2a: res_d = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      6'h2b: res_d = {{(WIDTH-1){1'b0}}, A < B};
      6'h00: res_d = B << shamt;
      6'h02: res_d = B >> shamt;
      6'h03: res_d = $signed(B) >>> shamt;
      6'h10: res_d = hi_q;
      6'h12: res_d = lo_q;
      default: ;
    endcase
  end
  // shift-add: hi accumulates the partial product, lo holds the remaining multiplier bits
  assign acc    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign mul_hi = acc[WIDTH:1];
  assign mul_lo = {acc[0], lo_q[WIDTH-1:1]};
  assign prod   = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
`ifdef ALU_DIV_EN
  logic div_q, negr_q, dz_q;
  logic [WIDTH-1:0] a_q, div_hi, div_lo, dsub;
  logic [WIDTH:0] sh;
  logic ge;
  // restoring: hi is the partial remainder, dividend bits leave lo's top as quotient bits enter its bottom
  assign sh      = {hi_q, lo_q[WIDTH-1]};
  assign ge      = sh >= {1'b0, b_q};
  assign dsub    = sh[WIDTH-1:0] - b_q;
  assign div_hi  = ge ? dsub : sh[WIDTH-1:0];
  assign div_lo  = {lo_q[WIDTH-2:0], ge};
  assign is_multi = is_mul || OpSel == 6'h1a || OpSel == 6'h1b;
  assign step_hi = div_q ? div_hi : mul_hi;
  assign step_lo = div_q ? div_lo : mul_lo;
  assign fin_hi  = !div_q ? prod[2*WIDTH-1:WIDTH] : dz_q ? a_q : negr_q ? -div_hi : div_hi;
  assign fin_lo  = !div_q ? prod[WIDTH-1:0] : dz_q ? '1 : neg_q ? -div_lo : div_lo;
`else
  assign is_multi = is_mul;
  assign step_hi  = mul_hi;
  assign step_lo  = mul_lo;
  assign fin_hi   = prod[2*WIDTH-1:WIDTH];
  assign fin_lo   = prod[WIDTH-1:0];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
`ifdef ALU_DIV_EN
      div_q   <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start && is_multi) begin
          state_q <= EXEC;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          hi_q    <= '0;
          lo_q    <= is_mul ? mag_b : mag_a;
          b_q     <= is_mul ? mag_a : mag_b;
          neg_q   <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef ALU_DIV_EN
          div_q   <= !is_mul;
          negr_q  <= is_signed && A[WIDTH-1];
          dz_q    <= B == '0;
          a_q     <= A;
`endif
        end else if (start) begin
          res_q  <= res_d;
          zero_q <= res_d == '0;
          ovf_q  <= ovf_d;
          done_q <= 1'b1;
          if (OpSel == 6'h11) hi_q <= A;
          if (OpSel == 6'h13) lo_q <= A;
        end
      end else begin
        cnt_q <= cnt_q + SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(WIDTH-1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          hi_q    <= fin_hi;
          lo_q    <= fin_lo;
        end else begin
          hi_q <= step_hi;
          lo_q <= step_lo;
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_alu_mc.sv
// tb_mips_alu_mc: directed vectors with a done-driven scoreboard monitor
module tb_mips_alu_mc;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [5:0] OpSel = '0;
  logic [31:0] A = '0, B = '0;
  logic [4:0] shamt = '0;
  logic [31:0] Res, hi, lo;
  logic zero, overflow, busy, done;
  int n_vec = 0, n_err = 0, id = 0;
  typedef struct {
    int id;
    logic [31:0] res;
    logic z;
    logic v;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0;
  logic m_v = 1'b0;

  mips_alu_mc dut (
    .clk(clk), .reset(reset), .start(start), .OpSel(OpSel), .A(A), .B(B), .shamt(shamt),
    .Res(Res), .zero(zero), .overflow(overflow), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done res=%h hi=%h lo=%h, no completion was due", Res, hi, lo);
      end else begin
        e = q.pop_front();
        if (Res !== e.res || zero !== e.z || overflow !== e.v || hi !== e.hi || lo !== e.lo) begin
          n_err++;
          $display("FAIL vec%0d got res=%h z=%b v=%b hi=%h lo=%h want res=%h z=%b v=%b hi=%h lo=%h",
                   e.id, Res, zero, overflow, hi, lo, e.res, e.z, e.v, e.hi, e.lo);
        end
      end
    end
  end

  function automatic void push();
    exp_t x;
    x.id = id;
    x.res = m_res;
    x.z = (m_res == 0);
    x.v = m_v;
    x.hi = m_hi;
    x.lo = m_lo;
    id++;
    q.push_back(x);
  endfunction

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    start = 1'b1; OpSel = op; A = a; B = b; shamt = sh;
    @(negedge clk);
  endtask

  task automatic sc(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                    input logic [31:0] res, input logic v);
    m_res = res; m_v = v;
    push();
    issue(op, a, b, sh);
  endtask

  task automatic mc(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] h, input logic [31:0] l, input int inj);
    int cyc, nb;
    m_hi = h; m_lo = l;
    push();
    issue(op, a, b, 5'd0);
    start = 1'b0;
    cyc = 0; nb = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      start = (inj != 0 && cyc == inj);
      if (start) begin OpSel = 6'h20; A = 32'd1; B = 32'd1; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL op%h_timeout done=%b after %0d cycles, required 1", op, done, cyc);
    end
    n_vec++;
    if (nb != 32) begin
      n_err++;
      $display("FAIL op%h_busy_cycles got %0d required 32", op, nb);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    n_vec++;
    if (Res !== 0 || zero !== 1 || overflow !== 0 || busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
      n_err++;
      $display("FAIL reset_state got res=%h z=%b v=%b busy=%b done=%b hi=%h lo=%h required 0/1/0/0/0/0/0",
               Res, zero, overflow, busy, done, hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
    sc(6'h20, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1'b1);
    sc(6'h21, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1'b0);
    sc(6'h22, 32'h5, 32'h5, 0, 32'h0, 1'b0);
    sc(6'h22, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 1'b1);
    sc(6'h2a, 32'hFFFFFFFF, 32'h1, 0, 32'h1, 1'b0);
    sc(6'h2b, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 1'b0);
    sc(6'h03, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0);
    sc(6'h02, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 1'b0);
    sc(6'h00, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0);
    sc(6'h24, 32'hF0F0, 32'hFF00, 0, 32'hF000, 1'b0);
    sc(6'h25, 32'hF0F0, 32'hFF00, 0, 32'hFFF0, 1'b0);
    sc(6'h26, 32'hF0F0, 32'hFF00, 0, 32'h0FF0, 1'b0);
    sc(6'h27, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 1'b0);
    sc(6'h3f, 32'h1, 32'h2, 0, 32'h0, 1'b0);
    m_hi = 32'h1234;
    sc(6'h11, 32'h1234, 32'h0, 0, 32'h0, 1'b0);
    sc(6'h10, 32'h0, 32'h0, 0, 32'h1234, 1'b0);
    m_lo = 32'h5678;
    sc(6'h13, 32'h5678, 32'h0, 0, 32'h0, 1'b0);
    sc(6'h12, 32'h0, 32'h0, 0, 32'h5678, 1'b0);
    start = 1'b0;
    @(negedge clk);
    mc(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    sc(6'h10, 32'h0, 32'h0, 0, 32'hFFFFFFFE, 1'b0);
    start = 1'b0;
    @(negedge clk);
    mc(6'h18, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
`ifdef ALU_DIV_EN
    mc(6'h1a, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    mc(6'h1b, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 0);
    mc(6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
`else
    sc(6'h1a, 32'hFFFFFFF9, 32'h2, 0, 32'h0, 1'b0);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL div_disabled_busy got %b required 0", busy);
    end
    sc(6'h1b, 32'h7, 32'h0, 0, 32'h0, 1'b0);
    start = 1'b0;
`endif
    mc(6'h18, 32'h2, 32'h3, 32'h0, 32'h6, 5);
    repeat (3) @(negedge clk);
    issue(6'h18, 32'h5, 32'h5, 0);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1; start = 1'b1; OpSel = 6'h20; A = 32'h1; B = 32'h1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_vec++;
    if (busy !== 0 || hi !== 0 || lo !== 0 || Res !== 0 || zero !== 1 || done !== 0) begin
      n_err++;
      $display("FAIL midop_reset got busy=%b hi=%h lo=%h res=%h z=%b done=%b required 0/0/0/0/1/0",
               busy, hi, lo, Res, zero, done);
    end
    m_res = '0; m_v = 1'b0; m_hi = '0; m_lo = '0;
    repeat (40) @(negedge clk);
    mc(6'h19, 32'h3, 32'h5, 32'h0, 32'hF, 0);
    repeat (5) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL pending_expectations got %0d required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
